// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame constants,
// and a small constant helper used to size counters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DBIT    = 8;
  localparam int UART_OVS     = 16;
  localparam int UART_SB_TICK = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit double-flop synchronizer for bringing an asynchronous
// level into the i_clk domain.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, both flops load INIT
//   i_d     : asynchronous input
//   o_q     : synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter logic INIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver driven by an oversampling baud tick.
// Deserializes i_rx LSB first and presents each byte with a one-cycle
// completion strobe and a framing-error flag.
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_b_tick    : one-cycle pulse at OVERSAMPLE x baud
//   i_rx        : asynchronous serial line, idles high
//   o_data      : last received byte, held until the next o_rx_done
//   o_rx_done   : one-cycle pulse when a frame completes
//   o_frame_err : one-cycle pulse with o_rx_done when the stop bit was low
//   o_busy      : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit, then confirm it or reject a glitch
// DATA  | sampling DATA_BITS data bits at mid-bit, LSB first
// STOP  | waiting out the stop window, then strobe the result
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DBIT,
  parameter int OVERSAMPLE = UART_OVS,
  parameter int SB_TICK    = UART_SB_TICK
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_b_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int S_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_d_q, rx_d_d;
  logic start_fall;

  uart_rx_state_t       state_q, state_d;
  logic [S_W-1:0]       s_cnt_q, s_cnt_d;
  logic [N_W-1:0]       n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false edge.
  sync_2ff #(
    .INIT (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Edge-only start detection: a held-low line (break) cannot retrigger.
  always_comb begin
    rx_d_d     = rx_s;
    start_fall = rx_d_q & ~rx_s;
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_fall) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (i_b_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      DATA: begin
        if (i_b_tick) begin
          if (s_cnt_q == S_BIT) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + N_W'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      STOP: begin
        if (i_b_tick) begin
          if (s_cnt_q == S_STOP) begin
            // A bad stop bit still delivers the byte; the flag lets the
            // consumer decide whether to keep it.
            data_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + S_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_d_q  <= 1'b1;
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_d_q  <= rx_d_d;
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a local tick divider stands in for the
// baud generator (one tick every 4 clocks), frames are driven bit by bit
// and every completion strobe is captured for comparison.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       b_tick;
  logic       rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  logic       tick_en;
  logic [1:0] tick_div;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_orphan = 0;
  int n_long   = 0;
  logic prev_done = 1'b0;

  logic [7:0] q_data[$];
  logic       q_ferr[$];
  logic       q_busy[$];

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SB_TICK    (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_b_tick    (b_tick),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    b_tick   <= tick_en && (tick_div == 2'd3);
  end

  always @(negedge clk) begin
    if (o_rx_done) begin
      n_done++;
      q_data.push_back(o_data);
      q_ferr.push_back(o_frame_err);
      q_busy.push_back(o_busy);
      if (prev_done) n_long++;
    end
    if (o_frame_err && !o_rx_done) n_orphan++;
    prev_done = o_rx_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * 16 + 16) begin
      @(posedge clk);
      cyc++;
      if (b_tick) got++;
    end
    if (got < n) check("tick_timeout", got, n);
    @(negedge clk);
  endtask

  // stall_bit < 0 means no stall; otherwise ticks are gated off for 500
  // cycles halfway through that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stall_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == stall_bit) begin
        wait_ticks(8);
        tick_en = 1'b0;
        repeat (500) @(negedge clk);
        check("stall_busy", o_busy, 1'b1);
        check("stall_no_done", q_data.size(), 0);
        tick_en = 1'b1;
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    rx = stop_lvl;
    wait_ticks(16);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp_data, input logic exp_ferr);
    if (q_data.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      check({tag, "_data"}, q_data.pop_front(), exp_data);
      check({tag, "_ferr"}, q_ferr.pop_front(), exp_ferr);
      check({tag, "_busy_at_done"}, q_busy.pop_front(), 1'b0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    tick_en  = 1'b1;
    tick_div = 2'd0;
    b_tick   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", o_data, 8'h00);
    check("rst_done", o_rx_done, 1'b0);
    check("rst_ferr", o_frame_err, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    wait_ticks(16);

    // Clean frame
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(16);
    check("a5_count", q_data.size(), 1);
    expect_frame("a5", 8'hA5, 1'b0);
    check("a5_busy_after", o_busy, 1'b0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    wait_ticks(16);
    check("b2b_count", q_data.size(), 3);
    expect_frame("b2b0", 8'h00, 1'b0);
    expect_frame("b2b1", 8'hFF, 1'b0);
    expect_frame("b2b2", 8'h3C, 1'b0);

    // Glitch: low for 3 ticks only
    rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_start", o_busy, 1'b1);
    rx = 1'b1;
    wait_ticks(32);
    check("glitch_busy_end", o_busy, 1'b0);
    check("glitch_no_done", q_data.size(), 0);
    check("glitch_data_kept", o_data, 8'h3C);

    // Framing error, then a 40-bit break
    send_frame(8'h55, 1'b0, -1);
    check("ferr_count", q_data.size(), 1);
    expect_frame("ferr", 8'h55, 1'b1);
    wait_ticks(40 * 16);
    check("break_no_done", q_data.size(), 0);
    check("break_busy", o_busy, 1'b0);
    rx = 1'b1;
    wait_ticks(16);
    check("break_release_no_done", q_data.size(), 0);
    send_frame(8'h5A, 1'b1, -1);
    wait_ticks(16);
    expect_frame("post_break", 8'h5A, 1'b0);

    // Reset during data bit 4 of 0x81
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    check("pre_rst_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", o_data, 8'h00);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_done", o_rx_done, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(16);
    check("midrst_no_strobe", q_data.size(), 0);
    send_frame(8'h81, 1'b1, -1);
    wait_ticks(16);
    expect_frame("post_rst", 8'h81, 1'b0);

    // Tick stall in the middle of data bit 3
    send_frame(8'hC3, 1'b1, 3);
    wait_ticks(16);
    check("stall_count", q_data.size(), 1);
    expect_frame("stall", 8'hC3, 1'b0);

    check("total_done", n_done, 8);
    check("ferr_orphan", n_orphan, 0);
    check("done_long", n_long, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver stage directly downstream of the `baudrate` tick generator. It consumes the generator's oversampling tick `o_b_tick` (16 ticks per bit period) and deserializes an asynchronous 8N1 line into parallel bytes, one at a time. Each byte is presented with a single-cycle completion strobe and a framing-error flag. Output feeds the RX FIFO / command decoder.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥4. Must match the baudrate generator.
- `SB_TICK`, 16: ticks spent sampling the stop bit (16 = 1 stop bit).
- `i_clk`, input, 1: system clock. All logic is on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_b_tick`, input, 1: one-cycle pulse from `baudrate`, at OVERSAMPLE × baud.
- `i_rx`, input, 1: serial line. Asynchronous to `i_clk`; idles high.
- `o_data`, output, DATA_BITS: last received byte. Held stable until the next `o_rx_done`.
- `o_rx_done`, output, 1: one-cycle pulse when a frame completes.
- `o_frame_err`, output, 1: one-cycle pulse, coincident with `o_rx_done`, when the stop bit sampled low.
- `o_busy`, output, 1: high in every state except IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer (`rx_s`), followed by one delay flop (`rx_d`). All three flops reset to 1.
- Start detection is on a falling edge only: `rx_d==1 && rx_s==0`. A line held low (break) therefore cannot retrigger reception.
- Counters: `s_cnt` has width $clog2(max(OVERSAMPLE,SB_TICK)). `n_cnt` has width $clog2(DATA_BITS). Both counters advance only on cycles where `i_b_tick` is high.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, go to START and clear `s_cnt`.
  - START: on a tick with `s_cnt==OVERSAMPLE/2-1` (mid start bit):
    - if `rx_s==0`, go to DATA and clear `s_cnt` and `n_cnt`;
    - otherwise it is a glitch: go to IDLE with no strobe.
    - On any other tick, increment `s_cnt`.
  - DATA: on a tick with `s_cnt==OVERSAMPLE-1`, shift right: `shreg <= {rx_s, shreg[DATA_BITS-1:1]}` and clear `s_cnt`.
    - If `n_cnt==DATA_BITS-1`, go to STOP; otherwise increment `n_cnt`.
    - On any other tick, increment `s_cnt`.
  - STOP: on a tick with `s_cnt==SB_TICK-1`:
    - load `o_data <= shreg`;
    - pulse `o_rx_done`;
    - set `o_frame_err <= ~rx_s`;
    - go to IDLE.
- A framing-error frame still loads `o_data`. Consumers decide whether to discard it.
- Missing ticks stall the FSM indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE; `o_data` 0; `o_rx_done` 0; `o_frame_err` 0; `o_busy` 0; counters 0; shift register 0.
- Synchronizer latency is 2 cycles. Edge detection adds 1 more, so START is entered 3 cycles after the `i_rx` fall.
- `o_rx_done` and `o_frame_err` are registered. They rise on the clock after the final stop tick and last exactly 1 cycle.
- `o_busy` drops in the same cycle as `o_rx_done`.
- Sampling points: mid-bit for data, i.e. OVERSAMPLE/2 + k·OVERSAMPLE ticks after the detected edge. Stop is sampled at the end of its SB_TICK window.
- A falling edge arriving in the same cycle as the STOP→IDLE transition is ignored. The next start must produce its edge while in IDLE. At 16× oversampling the idle stop level always provides that edge.
- Reset asserted mid-frame returns everything to reset values immediately and asynchronously. No strobe is emitted.

## Structure
- `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t`;
  - the default constants `UART_DBIT=8`, `UART_OVS=16`, `UART_SB_TICK=16`;
  - these are shared with the future `uart_tx`.
- Sub-module `sync_2ff`: a generic 1-bit double-flop synchronizer with an `INIT` reset-value parameter. `uart_rx` instantiates it with `INIT=1`.
- The FSM and counters live in `uart_rx`.

## Test plan
- Bench setup: 100 MHz clock, `baudrate` instance producing the tick.
- Clean frame: send 0xA5 (8N1) after reset → one `o_rx_done` pulse, `o_data==8'hA5`, `o_frame_err==0`, `o_busy` low afterwards.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap → exactly three done pulses carrying 0x00, 0xFF, 0x3C in that order, with no frame errors.
- Glitch: drive `i_rx` low for 3 ticks, then high → FSM returns to IDLE, no `o_rx_done`, `o_data` unchanged.
- Framing error: send 0x55 with the stop bit driven low → `o_rx_done` and `o_frame_err` pulse together, `o_data==8'h55`. Then hold the line low for 40 bit times → no further strobes until the line goes high and a new start arrives.
- Reset mid-frame: assert `i_rst_n=0` during data bit 4 of 0x81 → outputs return to reset values with no strobe. After release, send 0x81 → correct reception.
- Tick stall: gate `i_b_tick` off mid-DATA for 500 cycles, then resume → FSM holds state and the frame completes correctly.
